// File: rtl/serial_adder.sv
// Bit-serial adder: two half adders and an OR form a full adder,
// a carry flip-flop closes the loop across WIDTH clock cycles.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nx;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            load;
    logic            step;
    logic            last;
    logic            p;
    logic            g;
    logic            s_bit;
    logic            pc;
    logic            c_nx;

    half_adder u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(p),     .c(g));
    half_adder u_ha1 (.x(p),       .y(carry),   .s(s_bit), .c(pc));

    assign c_nx   = g | pc;
    assign last   = (cnt == CW'(WIDTH - 1));
    assign res_nx = {s_bit, res_sh[WIDTH-1:1]};

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                // Accepting here gives back-to-back operation.
                done = 1'b1;
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
            end
            if (step) begin
                a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                res_sh <= res_nx;
                carry  <= c_nx;
                cnt    <= cnt + CW'(1);
                if (last) begin
                    sum  <= res_nx;
                    cout <= c_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks for serial_adder at WIDTH=8.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xc, input string tag);
        logic [W:0]   exp;
        logic [W-1:0] prev;
        exp   = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
        prev  = sum;
        a     = xa;
        b     = xb;
        cin   = xc;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~xa;
        b     = ~xb;
        cin   = ~xc;
        for (int i = 0; i < W; i++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
            if (i == 0) chk({tag, "_hold"}, {24'd0, sum}, {24'd0, prev});
            tick();
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_res"}, {23'd0, cout, sum}, {23'd0, exp});
        tick();
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int c1;
        int c2;
        logic [W:0] r1;
        logic [W:0] r2;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'h00);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0;
        tick();

        run_op(8'hFF, 8'h01, 1'b0, "carry");
        chk("carry_val", {23'd0, cout, sum}, 32'h100);
        run_op(8'h5A, 8'hA5, 1'b1, "fullprop");
        chk("fullprop_val", {23'd0, cout, sum}, 32'h100);
        run_op(8'h12, 8'h34, 1'b0, "nocarry");
        chk("nocarry_val", {23'd0, cout, sum}, 32'h046);

        // Start pulse on the third RUN cycle must be ignored.
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a     = 8'h77;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            if (done) begin
                ndone++;
                chk("ign_sum", {23'd0, cout, sum}, 32'h046);
            end
            chk("ign_excl", {30'd0, busy, done} == 32'd3 ? 32'd1 : 32'd0,
                32'd0);
            tick();
        end
        chk("ign_ndone", ndone, 1);

        // Reset on the fourth RUN cycle aborts the operation.
        a     = 8'hF0;
        b     = 8'h33;
        cin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sum", {24'd0, sum}, 32'h00);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("abort_nodone", ndone, 0);

        // Back-to-back with start held high.
        a     = 8'h01;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        a     = 8'h80;
        b     = 8'h80;
        ndone = 0;
        c1    = -1;
        c2    = -1;
        r1    = '0;
        r2    = '0;
        for (int c = 0; c < 24; c++) begin
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    c1 = c;
                    r1 = {cout, sum};
                end else if (ndone == 2) begin
                    c2    = c;
                    r2    = {cout, sum};
                    start = 1'b0;
                end
            end
            tick();
        end
        start = 1'b0;
        chk("b2b_ndone", ndone, 2);
        chk("b2b_first_at", c1, 8);
        chk("b2b_gap", c2 - c1, 9);
        chk("b2b_r1", {23'd0, r1}, 32'h002);
        chk("b2b_r2", {23'd0, r2}, 32'h100);
        tick();

        for (int i = 0; i < 500; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
